// File: rtl/axi_pkg.sv
// Shared AXI3 constants and the responder FSM state encoding.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    RFETCH,
    RDATA
  } state_t;

endpackage

// File: rtl/bram_byte_sp.sv
// Single-port 32-bit block RAM with per-byte write enables and a registered read port.
module bram_byte_sp #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0] mem [WORDS];

  // rdata only updates on a read enable, so it holds while the responder waits on rready
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_bram_responder.sv
// AXI3 responder serving one read or write burst at a time from a byte-enabled BRAM.
// Optional AXI_RESPONDER_ERROR_CHECK_EN adds SLVERR for reserved bursts and wlast mismatches.
module axi_bram_responder
  import axi_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int ID_WIDTH   = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [31:0]         awaddr,
  input  logic [3:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic                wvalid,
  output logic                wready,
  input  logic [31:0]         wdata,
  input  logic [3:0]          wstrb,
  input  logic                wlast,
  input  logic [ID_WIDTH-1:0] wid,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  output logic [ID_WIDTH-1:0] bid,
  input  logic                arvalid,
  output logic                arready,
  input  logic [31:0]         araddr,
  input  logic [3:0]          arlen,
  input  logic [1:0]          arburst,
  input  logic [ID_WIDTH-1:0] arid,
  output logic                rvalid,
  input  logic                rready,
  output logic [31:0]         rdata,
  output logic [1:0]          rresp,
  output logic [ID_WIDTH-1:0] rid,
  output logic                rlast
);

  state_t                state;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [3:0]            len;
  logic [3:0]            count;
  logic [1:0]            burst;
  logic [ID_WIDTH-1:0]   id;
  logic                  wlast_err;
  logic [31:0]           ram_rdata;
  logic [3:0]            ram_we;
  logic                  last_beat;
  logic                  w_fire;
  logic                  burst_err;
  logic                  hold_addr;
  logic                  unused_bits;

  assign last_beat = (count == len);
  assign w_fire    = (state == WRITE) && wvalid;
  assign hold_addr = (burst == BURST_FIXED);

`ifdef AXI_RESPONDER_ERROR_CHECK_EN
  assign burst_err = burst[1];
`else
  assign burst_err = 1'b0;
`endif

  // Reserved bursts never touch memory; writes are also blocked during the reset cycle
  assign ram_we = (w_fire && !burst_err && !reset) ? wstrb : 4'b0000;

  bram_byte_sp #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clock (clock),
    .en    (state == RFETCH),
    .we    (ram_we),
    .addr  (word_idx),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  assign awready = (state == IDLE);
  assign arready = (state == IDLE) && !awvalid;
  assign wready  = (state == WRITE);
  assign bvalid  = (state == WRESP);
  assign rvalid  = (state == RDATA);
  assign bid     = id;
  assign rid     = id;
  assign rlast   = rvalid && last_beat;
  assign rdata   = (rvalid && !burst_err) ? ram_rdata : 32'h0;
  assign bresp   = (bvalid && (burst_err || wlast_err)) ? RESP_SLVERR : RESP_OKAY;
  assign rresp   = (rvalid && burst_err) ? RESP_SLVERR : RESP_OKAY;

  assign unused_bits = ^{wid, wlast, awaddr[31:DEPTH_LOG2+2], awaddr[1:0],
                         araddr[31:DEPTH_LOG2+2], araddr[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      word_idx  <= '0;
      len       <= 4'd0;
      count     <= 4'd0;
      burst     <= BURST_FIXED;
      id        <= '0;
      wlast_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (awvalid) begin
            state     <= WRITE;
            word_idx  <= awaddr[DEPTH_LOG2+1:2];
            len       <= awlen;
            burst     <= awburst;
            id        <= awid;
            count     <= 4'd0;
            wlast_err <= 1'b0;
          end else if (arvalid) begin
            state     <= RFETCH;
            word_idx  <= araddr[DEPTH_LOG2+1:2];
            len       <= arlen;
            burst     <= arburst;
            id        <= arid;
            count     <= 4'd0;
            wlast_err <= 1'b0;
          end
        end
        WRITE: begin
          if (wvalid) begin
            count <= count + 4'd1;
            if (!hold_addr) word_idx <= word_idx + DEPTH_LOG2'(1);
`ifdef AXI_RESPONDER_ERROR_CHECK_EN
            if (wlast != last_beat) wlast_err <= 1'b1;
`endif
            if (last_beat) state <= WRESP;
          end
        end
        WRESP: begin
          if (bready) state <= IDLE;
        end
        RFETCH: begin
          state <= RDATA;
        end
        RDATA: begin
          if (rready) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              count <= count + 4'd1;
              if (!hold_addr) word_idx <= word_idx + DEPTH_LOG2'(1);
              state <= RFETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_bram_responder.md
# axi_bram_responder

AXI3 slave (responder) that serves single-beat and burst read/write transactions from an on-chip byte-enabled block RAM. It is the far end of the 32-bit AXI3 link our DRAM master drives, used as a DRAM stand-in for simulation and for FPGA bring-up without the memory controller. It processes one transaction at a time: no interleaving and no outstanding-transaction queue.

## Interface
Parameters:
- DEPTH_LOG2, 12, log2 of RAM depth in 32-bit words.
- ID_WIDTH, 6, width of all ID fields.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- awvalid / awready  in / out  1  write-address handshake
- awaddr  in  32  byte address
- awlen  in  4  beats minus 1
- awburst  in  2  burst type
- awid  in  ID_WIDTH  write ID
- wvalid / wready  in / out  1  write-data handshake
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- wlast  in  1  final write beat
- wid  in  ID_WIDTH  ignored
- bvalid / bready  out / in  1  write-response handshake
- bresp  out  2  write response
- bid  out  ID_WIDTH  write-response ID
- arvalid / arready  in / out  1  read-address handshake
- araddr  in  32  byte address
- arlen  in  4  beats minus 1
- arburst  in  2  burst type
- arid  in  ID_WIDTH  read ID
- rvalid / rready  out / in  1  read-data handshake
- rdata  out  32  read data
- rresp  out  2  read response
- rid  out  ID_WIDTH  read-data ID
- rlast  out  1  final read beat

## Operation
- FSM states: IDLE, WRITE, WRESP, RFETCH, RDATA.
- **IDLE**
  - awready=1.
  - arready = !awvalid, so writes win when both channels are valid.
  - On a handshake, capture address, len, burst and ID, and clear the beat counter.
  - AW handshake goes to WRITE; AR handshake goes to RFETCH.
- **Addressing**
  - Word index = addr[DEPTH_LOG2+1:2]; addr[1:0] is ignored.
  - Higher address bits alias.
  - INCR (01): word index increments after each beat, modulo 2^DEPTH_LOG2, so bursts wrap past the top of memory to word 0.
  - FIXED (00): word index is held for the whole burst.
- **WRITE**
  - wready=1.
  - Each W handshake writes the bytes enabled by wstrb and increments the beat counter.
  - The beat where counter==len is the last beat; the next state is WRESP.
- **WRESP**
  - bvalid=1 with bid = captured ID and bresp set.
  - Return to IDLE on bready.
- **RFETCH**
  - Present the word index to the RAM (synchronous read, 1-cycle latency).
  - Go to RDATA.
- **RDATA**
  - rvalid=1, rdata = RAM output held stable, rid = captured ID.
  - rlast = (counter==len).
  - On rready: if last, go to IDLE; else advance the address and counter and go to RFETCH.
- **Reset mid-operation**
  - FSM returns to IDLE and all valid outputs drop.
  - An in-flight burst is abandoned without a response.
  - RAM contents are untouched.
- All outputs reset to 0 except awready and arready, which follow IDLE (1 immediately after reset).

## Timing
- AW handshake in cycle N: wready is high from N+1.
- Last W handshake in cycle M: bvalid in M+1. Back-to-back W beats are accepted every cycle.
- AR handshake in cycle N: rvalid in N+2.
- R handshake in cycle K (not last): next rvalid in K+2. Read throughput is 1 beat per 2 cycles.
- Final B or R handshake in cycle K: IDLE in K+1, a new address is accepted in K+1.
- rdata, rid, rresp and rlast stay constant while rvalid && !rready.

## Configuration
- Macro: AXI_RESPONDER_ERROR_CHECK_EN.
- **Defined:**
  - Burst type 10 or 11 gives SLVERR (2'b10) on every R beat, with rdata=0.
  - On a write, that burst type suppresses the RAM writes and returns bresp=SLVERR.
  - A W beat whose wlast disagrees with (counter==len) latches an error; the burst still completes by count and returns bresp=SLVERR.
- **Undefined:**
  - Burst types 10 and 11 are treated as INCR.
  - wlast is ignored.
  - bresp and rresp are always OKAY (00).

## Structure
- Package axi_pkg holds:
  - burst constants BURST_FIXED, BURST_INCR;
  - response constants RESP_OKAY, RESP_SLVERR;
  - the FSM state enum.
- Sub-module bram_byte_sp: single-port RAM with 4-bit byte-write enable and registered read, parameterised by DEPTH_LOG2.

## Test plan
- Single write, then read: awaddr=0x10, wdata=0xDEADBEEF, wstrb=1111, then read araddr=0x10 → bresp=00, then rdata=0xDEADBEEF with rlast=1 and rid equal to arid.
- INCR burst: awlen=3 at 0x100 with data 1,2,3,4, then read arlen=3 → beats 1,2,3,4 with rlast only on beat 4, and bvalid exactly one cycle after the 4th W beat.
- Strobes and FIXED: write 0xAABBCCDD with wstrb=0101 over 0x11111111 → 0x11BB11DD; a FIXED write burst of 2 beats leaves only beat 2's data at the address.
- Backpressure and wrap: read burst arlen=1 starting at the top word with rready low for 5 cycles → rdata held stable, then the second beat comes from word 0.
- Arbitration and reset: awvalid and arvalid asserted together → the write completes first; reset asserted mid read burst → rvalid=0 next cycle and arready=1.
- Error checking (macro defined): arburst=10 → rresp=10 and rdata=0; wlast high on beat 1 of an awlen=2 burst → bresp=10.
